stacking_loop_sequencer: RTL and testbench
==========================================

STACKING_LOOP_SEQUENCER -- requirements
Module: stacking_loop_sequencer

Interface
REQ-001 SHALL have parameter OUT_X_MAX, default 16: maximum output row width (sub-chunks per filter row).
REQ-002 SHALL have parameter FIL_Y_MAX, default 7: maximum filter rows.
REQ-003 SHALL have parameter FIL_X_MAX, default 7: filter width, used as the sparsemap row pitch.
REQ-004 SHALL have parameter CH_MAX, default 64: maximum sub-channel size.
REQ-005 SHALL have parameter PS_SIZE, default 32: prefix-sum width; power of two.
REQ-006 SHALL have parameter BUF_NUM, default 128: accumulator buffer count.
REQ-007 SHALL have ports, clock and reset first:
- clk_i  in  1  single clock; all logic on rising edge, no gated clocks.
- rst_i  in  1  reset, synchronous, active-low.
- start_i  in  1  one-cycle start pulse.
- abort_i  in  1  cancel the current loop.
- cfg_out_x_i  in  clog2(OUT_X_MAX+1)  output width, 1..OUT_X_MAX.
- cfg_stride2_i  in  1  0 = stride 1, 1 = stride 2.
- cfg_sub_ch_i  in  clog2(CH_MAX+1)  sub-channel size, 1..CH_MAX.
- cfg_fil_y_start_i / cfg_fil_y_last_i  in  clog2(FIL_Y_MAX)  first/last filter row.
- cfg_fil_y_step_i  in  clog2(FIL_X_MAX+1)  sparsemap words per filter row.
- ifm_y_idx_i  in  clog2(OUT_X_MAX*FIL_Y_MAX)  current IFM row.
- chunk_done_i  in  1  sub-chunk compute finished.
- busy_o  out  1; done_o  out  1; err_o  out  1; sub_chunk_start_o  out  1.
- fil_sm_first_o, fil_sm_last_o  out  clog2(FIL_Y_MAX*FIL_X_MAX+1)  filter sparsemap range.
- fil_nz_first_o  out  clog2(FIL_Y_MAX)  filter nonzero-data row.
- ifm_sm_first_o  out  clog2(2*OUT_X_MAX*CH_MAX/PS_SIZE+1)  IFM sparsemap word.
- sm_shift_o  out  clog2(PS_SIZE)  sparsemap left shift.
- ifm_sm_next_o  out  clog2(2*CH_MAX)  extra IFM sparsemap words to read.
- acc_buf_sel_o  out  clog2(BUF_NUM)  accumulator select; acc_buf_vld_o  out  1  select valid.

Function
REQ-008 SHALL implement FSM IDLE -> ISSUE -> WAIT -> (ISSUE | DONE) -> IDLE.
REQ-009 SHALL, on start_i in IDLE, latch all cfg_* inputs, set x_idx=0, x_dat=0, fil_y=cfg_fil_y_start_i, and enter ISSUE; start_i outside IDLE SHALL be ignored and set err_o.
REQ-010 SHALL assert sub_chunk_start_o exactly while in ISSUE (one cycle), then enter WAIT.
REQ-011 SHALL, on chunk_done_i in WAIT at a non-final position, advance the counters and return to ISSUE; chunk_done_i in IDLE/ISSUE/DONE SHALL be ignored and set err_o.
REQ-012 SHALL advance counters as follows: if x_idx == out_x-1, x_idx=0, x_dat=0, fil_y+=1; else x_idx+=1, x_dat+=sub_ch*(stride2?2:1).
REQ-013 SHALL treat the position x_idx==out_x-1 with fil_y==fil_y_last as final; chunk_done_i there SHALL enter DONE.
REQ-014 SHALL assert done_o only in DONE (one cycle), then enter IDLE with counters held.
REQ-015 SHALL assert busy_o in every state except IDLE.
REQ-016 SHALL, on abort_i, enter IDLE next cycle without done_o; abort_i has priority over chunk_done_i.
REQ-017 SHALL drive, combinationally from registered state:
- fil_sm_first_o = fil_y*FIL_X_MAX
- fil_sm_last_o = fil_sm_first_o + fil_y_step - 1
- fil_nz_first_o = fil_y
- ifm_sm_first_o = x_dat / PS_SIZE
- sm_shift_o = x_dat % PS_SIZE
- ifm_sm_next_o = 0 if x_idx == out_x-1, else sub_ch*(stride2?2:1) - 1
- acc_buf_sel_o = ((ifm_y_idx_i - fil_y)*out_x + x_idx) mod BUF_NUM
- acc_buf_vld_o = busy_o && (ifm_y_idx_i >= fil_y)
REQ-018 SHALL size internal arithmetic so no intermediate overflows at parameter maxima.
REQ-019 SHALL keep err_o sticky until reset or the next accepted start_i.

Reset
REQ-020 SHALL, with rst_i low at a clock edge, enter IDLE and clear every register: x_idx, x_dat, fil_y and err_o to 0; all outputs then read busy_o=0, done_o=0, sub_chunk_start_o=0, acc_buf_vld_o=0, err_o=0, index outputs 0. This applies mid-loop with no done_o.

Verification
REQ-021 Basic loop: out_x=4, sub_ch=8, stride1, fil_y 0..2 -> 12 sub_chunk_start_o pulses; done_o one cycle after 12th chunk_done_i; at x=1 ifm_sm_first_o=0, sm_shift_o=8.
REQ-022 Stride 2: sub_ch=24, out_x=3 -> at x=1 first=1, shift=16; at x=2 first=3, shift=0, ifm_sm_next_o=0.
REQ-023 Accumulator select: ifm_y=3, fil_y 1..2, out_x=4 -> fil_y=1,x=2 gives acc_buf_sel_o=10; ifm_y=0, fil_y=1 gives acc_buf_vld_o=0.
REQ-024 Protocol errors: chunk_done_i in ISSUE and start_i in WAIT -> counters unchanged, err_o=1; err_o clears on next accepted start_i.
REQ-025 Abort and reset: abort_i in WAIT -> IDLE next cycle, no done_o; rst_i low mid-loop -> all outputs 0 next cycle.
REQ-026 Single-chunk loop: out_x=1, fil_y_start=fil_y_last=2 -> one sub_chunk_start_o, fil_sm_first_o=14, done_o after first chunk_done_i.

Source files
------------

// File: rtl/stacking_loop_sequencer.sv
// Sequences sub-chunk issues over an output row and filter rows for stacked convolution,
// deriving sparsemap and accumulator-buffer addresses from the loop position.
module stacking_loop_sequencer #(
  parameter int unsigned OUT_X_MAX = 16,
  parameter int unsigned FIL_Y_MAX = 7,
  parameter int unsigned FIL_X_MAX = 7,
  parameter int unsigned CH_MAX    = 64,
  parameter int unsigned PS_SIZE   = 32,
  parameter int unsigned BUF_NUM   = 128,
  localparam int unsigned OXW = $clog2(OUT_X_MAX + 1),
  localparam int unsigned SCW = $clog2(CH_MAX + 1),
  localparam int unsigned FYW = $clog2(FIL_Y_MAX),
  localparam int unsigned STW = $clog2(FIL_X_MAX + 1),
  localparam int unsigned IYW = $clog2(OUT_X_MAX * FIL_Y_MAX),
  localparam int unsigned SMW = $clog2(FIL_Y_MAX * FIL_X_MAX + 1),
  localparam int unsigned IFW = $clog2(2 * OUT_X_MAX * CH_MAX / PS_SIZE + 1),
  localparam int unsigned SHW = $clog2(PS_SIZE),
  localparam int unsigned NXW = $clog2(2 * CH_MAX),
  localparam int unsigned ABW = $clog2(BUF_NUM)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic           abort_i,
  input  logic [OXW-1:0] cfg_out_x_i,
  input  logic           cfg_stride2_i,
  input  logic [SCW-1:0] cfg_sub_ch_i,
  input  logic [FYW-1:0] cfg_fil_y_start_i,
  input  logic [FYW-1:0] cfg_fil_y_last_i,
  input  logic [STW-1:0] cfg_fil_y_step_i,
  input  logic [IYW-1:0] ifm_y_idx_i,
  input  logic           chunk_done_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           err_o,
  output logic           sub_chunk_start_o,
  output logic [SMW-1:0] fil_sm_first_o,
  output logic [SMW-1:0] fil_sm_last_o,
  output logic [FYW-1:0] fil_nz_first_o,
  output logic [IFW-1:0] ifm_sm_first_o,
  output logic [SHW-1:0] sm_shift_o,
  output logic [NXW-1:0] ifm_sm_next_o,
  output logic [ABW-1:0] acc_buf_sel_o,
  output logic           acc_buf_vld_o
);

  localparam int unsigned XDW  = $clog2(2 * OUT_X_MAX * CH_MAX + 1);
  localparam int unsigned STPW = SCW + 1;
  localparam int unsigned OXW1 = OXW + 1;
  localparam int unsigned AW   = IYW + OXW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e           state_q, state_d;
  logic [OXW-1:0]   x_idx_q, x_idx_d;
  logic [XDW-1:0]   x_dat_q, x_dat_d;
  logic [FYW-1:0]   fil_y_q, fil_y_d;
  logic             err_q, err_d;
  logic [OXW-1:0]   out_x_q, out_x_d;
  logic             stride2_q, stride2_d;
  logic [SCW-1:0]   sub_ch_q, sub_ch_d;
  logic [FYW-1:0]   fil_y_last_q, fil_y_last_d;
  logic [STW-1:0]   fil_y_step_q, fil_y_step_d;

  logic             last_x;
  logic             final_pos;
  logic [STPW-1:0]  x_step;
  logic [AW-1:0]    acc_diff;
  logic [AW-1:0]    acc_lin;

  assign x_step    = STPW'(sub_ch_q) << stride2_q;
  // Widened compare so a cleared out_x of zero never matches x_idx.
  assign last_x    = (OXW1'(x_idx_q) + OXW1'(1)) == OXW1'(out_x_q);
  assign final_pos = last_x && (fil_y_q == fil_y_last_q);

  always_comb begin
    state_d      = state_q;
    x_idx_d      = x_idx_q;
    x_dat_d      = x_dat_q;
    fil_y_d      = fil_y_q;
    err_d        = err_q;
    out_x_d      = out_x_q;
    stride2_d    = stride2_q;
    sub_ch_d     = sub_ch_q;
    fil_y_last_d = fil_y_last_q;
    fil_y_step_d = fil_y_step_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          out_x_d      = cfg_out_x_i;
          stride2_d    = cfg_stride2_i;
          sub_ch_d     = cfg_sub_ch_i;
          fil_y_last_d = cfg_fil_y_last_i;
          fil_y_step_d = cfg_fil_y_step_i;
          x_idx_d      = '0;
          x_dat_d      = '0;
          fil_y_d      = cfg_fil_y_start_i;
          err_d        = 1'b0;
          state_d      = StIssue;
        end
        if (chunk_done_i) err_d = 1'b1;
      end
      StIssue: begin
        state_d = StWait;
        if (chunk_done_i) err_d = 1'b1;
      end
      StWait: begin
        if (chunk_done_i) begin
          if (final_pos) begin
            state_d = StDone;
          end else begin
            state_d = StIssue;
            if (last_x) begin
              x_idx_d = '0;
              x_dat_d = '0;
              fil_y_d = fil_y_q + FYW'(1);
            end else begin
              x_idx_d = x_idx_q + OXW'(1);
              x_dat_d = x_dat_q + XDW'(x_step);
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        if (chunk_done_i) err_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (start_i && (state_q != StIdle)) err_d = 1'b1;

    // Abort wins over a coincident chunk_done: nothing advances and it is not an error.
    if (abort_i && (state_q != StIdle)) begin
      state_d = StIdle;
      x_idx_d = x_idx_q;
      x_dat_d = x_dat_q;
      fil_y_d = fil_y_q;
      err_d   = err_q | start_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= StIdle;
      x_idx_q      <= '0;
      x_dat_q      <= '0;
      fil_y_q      <= '0;
      err_q        <= 1'b0;
      out_x_q      <= '0;
      stride2_q    <= 1'b0;
      sub_ch_q     <= '0;
      fil_y_last_q <= '0;
      fil_y_step_q <= '0;
    end else begin
      state_q      <= state_d;
      x_idx_q      <= x_idx_d;
      x_dat_q      <= x_dat_d;
      fil_y_q      <= fil_y_d;
      err_q        <= err_d;
      out_x_q      <= out_x_d;
      stride2_q    <= stride2_d;
      sub_ch_q     <= sub_ch_d;
      fil_y_last_q <= fil_y_last_d;
      fil_y_step_q <= fil_y_step_d;
    end
  end

  assign busy_o            = (state_q != StIdle);
  assign done_o            = (state_q == StDone);
  assign sub_chunk_start_o = (state_q == StIssue);
  assign err_o             = err_q;

  assign fil_sm_first_o = SMW'(fil_y_q) * SMW'(FIL_X_MAX);
  // An empty row range collapses onto its first word instead of wrapping.
  assign fil_sm_last_o  = (fil_y_step_q == '0) ? fil_sm_first_o
                        : fil_sm_first_o + SMW'(fil_y_step_q) - SMW'(1);
  assign fil_nz_first_o = fil_y_q;
  assign ifm_sm_first_o = IFW'(x_dat_q >> SHW);
  assign sm_shift_o     = x_dat_q[SHW-1:0];
  assign ifm_sm_next_o  = (last_x || (x_step == '0)) ? '0 : NXW'(x_step - STPW'(1));

  assign acc_diff      = AW'(ifm_y_idx_i) - AW'(fil_y_q);
  assign acc_lin       = acc_diff * AW'(out_x_q) + AW'(x_idx_q);
  assign acc_buf_sel_o = ABW'(acc_lin % AW'(BUF_NUM));
  assign acc_buf_vld_o = busy_o && (AW'(ifm_y_idx_i) >= AW'(fil_y_q));

endmodule

// File: tb/tb_stacking_loop_sequencer.sv
// Directed bench for stacking_loop_sequencer: loop walk, stride 2, accumulator select,
// protocol errors, abort, reset and single-chunk loops against hand-computed values.
module tb_stacking_loop_sequencer;

  localparam int unsigned OXW = 5;
  localparam int unsigned SCW = 7;
  localparam int unsigned FYW = 3;
  localparam int unsigned STW = 3;
  localparam int unsigned IYW = 7;
  localparam int unsigned SMW = 6;
  localparam int unsigned IFW = 7;
  localparam int unsigned SHW = 5;
  localparam int unsigned NXW = 7;
  localparam int unsigned ABW = 7;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [OXW-1:0] out_x = '0;
  logic           stride2 = 1'b0;
  logic [SCW-1:0] sub_ch = '0;
  logic [FYW-1:0] y_start = '0;
  logic [FYW-1:0] y_last = '0;
  logic [STW-1:0] y_step = '0;
  logic [IYW-1:0] ifm_y = '0;
  logic           chunk_done = 1'b0;
  logic           busy, done, err, scs, vld;
  logic [SMW-1:0] sm_first, sm_last;
  logic [FYW-1:0] nz_first;
  logic [IFW-1:0] ifm_first;
  logic [SHW-1:0] shift;
  logic [NXW-1:0] ifm_next;
  logic [ABW-1:0] sel;

  int errors = 0;
  int checks = 0;
  int pulses;

  stacking_loop_sequencer dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .start_i           (start),
    .abort_i           (abort),
    .cfg_out_x_i       (out_x),
    .cfg_stride2_i     (stride2),
    .cfg_sub_ch_i      (sub_ch),
    .cfg_fil_y_start_i (y_start),
    .cfg_fil_y_last_i  (y_last),
    .cfg_fil_y_step_i  (y_step),
    .ifm_y_idx_i       (ifm_y),
    .chunk_done_i      (chunk_done),
    .busy_o            (busy),
    .done_o            (done),
    .err_o             (err),
    .sub_chunk_start_o (scs),
    .fil_sm_first_o    (sm_first),
    .fil_sm_last_o     (sm_last),
    .fil_nz_first_o    (nz_first),
    .ifm_sm_first_o    (ifm_first),
    .sm_shift_o        (shift),
    .ifm_sm_next_o     (ifm_next),
    .acc_buf_sel_o     (sel),
    .acc_buf_vld_o     (vld)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // From ISSUE: move to WAIT, then complete the sub-chunk.
  task automatic chunk();
    if (scs) pulses++;
    tick();
    check_eq("wait_no_scs", scs, 0);
    chunk_done = 1'b1;
    tick();
    chunk_done = 1'b0;
  endtask

  task automatic config_loop(input int ox, input int sc, input int s2, input int ys,
                             input int yl, input int iy);
    out_x   = OXW'(ox);
    sub_ch  = SCW'(sc);
    stride2 = s2[0];
    y_start = FYW'(ys);
    y_last  = FYW'(yl);
    y_step  = 3'd7;
    ifm_y   = IYW'(iy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    ifm_y = 7'd3;
    tick();
    tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_scs", scs, 0);
    check_eq("rst_vld", vld, 0);
    check_eq("rst_sm_last", sm_last, 0);
    check_eq("rst_ifm_next", ifm_next, 0);
    check_eq("rst_sel", sel, 0);
    rst = 1'b1;

    // Basic loop: out_x=4, sub_ch=8, stride 1, fil_y 0..2
    config_loop(4, 8, 0, 0, 2, 2);
    do_start();
    pulses = 0;
    check_eq("b_scs", scs, 1);
    check_eq("b_busy", busy, 1);
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin
        check_eq("b0_sm_first", sm_first, 0);
        check_eq("b0_sm_last", sm_last, 6);
      end
      if (i == 1) begin
        check_eq("b1_ifm_first", ifm_first, 0);
        check_eq("b1_shift", shift, 8);
        check_eq("b1_next", ifm_next, 7);
      end
      if (i == 3) begin
        check_eq("b3_shift", shift, 24);
        check_eq("b3_next", ifm_next, 0);
      end
      if (i == 4) begin
        check_eq("b4_sm_first", sm_first, 7);
        check_eq("b4_sm_last", sm_last, 13);
        check_eq("b4_nz", nz_first, 1);
        check_eq("b4_shift", shift, 0);
      end
      if (i == 11) check_eq("b11_nz", nz_first, 2);
      check_eq("b_no_done", done, 0);
      chunk();
    end
    check_eq("b_pulses", pulses, 12);
    check_eq("b_done", done, 1);
    check_eq("b_done_busy", busy, 1);
    tick();
    check_eq("b_done_1cyc", done, 0);
    check_eq("b_idle_busy", busy, 0);
    check_eq("b_err", err, 0);

    // Stride 2: out_x=3, sub_ch=24
    config_loop(3, 24, 1, 0, 0, 0);
    do_start();
    chunk();
    check_eq("s1_first", ifm_first, 1);
    check_eq("s1_shift", shift, 16);
    check_eq("s1_next", ifm_next, 47);
    chunk();
    check_eq("s2_first", ifm_first, 3);
    check_eq("s2_shift", shift, 0);
    check_eq("s2_next", ifm_next, 0);
    chunk();
    check_eq("s_done", done, 1);
    tick();

    // Accumulator select, then abort in WAIT together with chunk_done
    config_loop(4, 8, 0, 1, 2, 3);
    do_start();
    check_eq("a0_sel", sel, 8);
    check_eq("a0_vld", vld, 1);
    chunk();
    chunk();
    check_eq("a2_sel", sel, 10);
    ifm_y = 7'd0;
    #1;
    check_eq("a_vld_low", vld, 0);
    tick();
    check_eq("a_wait_busy", busy, 1);
    abort = 1'b1;
    chunk_done = 1'b1;
    tick();
    abort = 1'b0;
    chunk_done = 1'b0;
    check_eq("ab_busy", busy, 0);
    check_eq("ab_done", done, 0);
    check_eq("ab_err", err, 0);
    check_eq("ab_shift_held", shift, 16);
    tick();
    check_eq("ab_done_later", done, 0);

    // Protocol errors
    config_loop(4, 8, 0, 0, 0, 0);
    do_start();
    chunk_done = 1'b1;
    tick();
    chunk_done = 1'b0;
    check_eq("e1_err", err, 1);
    check_eq("e1_shift", shift, 0);
    check_eq("e1_wait", scs, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("e2_err", err, 1);
    check_eq("e2_shift", shift, 0);
    check_eq("e2_scs", scs, 0);
    check_eq("e2_busy", busy, 1);
    chunk_done = 1'b1;
    tick();
    chunk_done = 1'b0;
    check_eq("e3_scs", scs, 1);
    check_eq("e3_shift", shift, 8);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("e4_err_sticky", err, 1);
    chunk_done = 1'b1;
    tick();
    chunk_done = 1'b0;
    check_eq("e5_idle_err", err, 1);

    // Single-chunk loop; the accepted start clears err
    config_loop(1, 8, 0, 2, 2, 0);
    do_start();
    pulses = 0;
    check_eq("o_err_clr", err, 0);
    check_eq("o_sm_first", sm_first, 14);
    check_eq("o_sm_last", sm_last, 20);
    check_eq("o_next", ifm_next, 0);
    chunk();
    check_eq("o_pulses", pulses, 1);
    check_eq("o_done", done, 1);
    tick();
    check_eq("o_idle", busy, 0);

    // Reset mid-loop
    config_loop(4, 8, 0, 0, 2, 3);
    do_start();
    for (int i = 0; i < 5; i++) chunk();
    check_eq("r_pre_nz", nz_first, 1);
    check_eq("r_pre_shift", shift, 8);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("r_pre_err", err, 1);
    rst = 1'b0;
    tick();
    check_eq("r_busy", busy, 0);
    check_eq("r_done", done, 0);
    check_eq("r_scs", scs, 0);
    check_eq("r_vld", vld, 0);
    check_eq("r_err", err, 0);
    check_eq("r_sm_first", sm_first, 0);
    check_eq("r_sm_last", sm_last, 0);
    check_eq("r_nz", nz_first, 0);
    check_eq("r_ifm_first", ifm_first, 0);
    check_eq("r_shift", shift, 0);
    check_eq("r_next", ifm_next, 0);
    check_eq("r_sel", sel, 0);
    rst = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
